// File: rtl/bidir_arb_pkg.sv
// bidir_arb_pkg: shared FSM state encoding and owner ids for the bidirectional RAM arbiter.
package bidir_arb_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;
    localparam logic OWNER0 = 1'b0;
    localparam logic OWNER1 = 1'b1;
endpackage

// File: rtl/bidir_arb_rsp.sv
// bidir_arb_rsp: one-cycle read response tracker; registers read-grant valid and owner id.
module bidir_arb_rsp
    import bidir_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic rd_vld,
    input  logic rd_id,
    output logic rvalid0,
    output logic rvalid1
);
    logic vld_q, vld_d, id_q, id_d;
    always_comb begin
        vld_d = rd_vld & ~rst;
        id_d  = rd_vld ? rd_id : id_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
            id_q  <= OWNER0;
        end else begin
            vld_q <= vld_d;
            id_q  <= id_d;
        end
    end
    // a response already in flight is suppressed while reset is held
    assign rvalid0 = vld_q & ~rst & (id_q == OWNER0);
    assign rvalid1 = vld_q & ~rst & (id_q == OWNER1);
endmodule

// File: rtl/bidir_ram_arbiter.sv
// bidir_ram_arbiter: two requesters sharing one single-port RAM, round robin with burst limit.
// Define BIDIR_ARB_FIXED_PRIO_EN for strict requester-0 priority (burst limit ignored).
module bidir_ram_arbiter
    import bidir_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_d,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_q
);
    localparam int BW = $clog2(MAX_BURST) + 1;
    localparam logic [BW-1:0] BMAX = BW'(MAX_BURST);

    state_t                state_q, state_d;
    logic                  last_q, last_d;
    logic [BW-1:0]         burst_q, burst_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic                  pick1;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
`ifdef BIDIR_ARB_FIXED_PRIO_EN
        pick1 = 1'b0;
`else
        // who wins when both request: opposite of last owner from IDLE, else owner until burst is spent
        pick1 = (state_q == IDLE) ? (last_q == OWNER0) :
                (state_q == OWN0) ? (burst_q >= BMAX) : (burst_q < BMAX);
`endif
        if (!rst) begin
            gnt0 = req0 & ~(req1 & pick1);
            gnt1 = req1 & ~(req0 & ~pick1);
        end
        state_d    = gnt0 ? OWN0 : gnt1 ? OWN1 : IDLE;
        last_d     = gnt0 ? OWNER0 : gnt1 ? OWNER1 : last_q;
        burst_d    = (state_d == IDLE) ? '0 :
                     (state_d != state_q) ? BW'(1) :
                     (burst_q == BMAX) ? burst_q : burst_q + 1'b1;
        ram_addr_d = gnt0 ? addr0 : gnt1 ? addr1 : ram_addr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= OWNER1;
            burst_q    <= '0;
            ram_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            burst_q    <= burst_d;
            ram_addr_q <= ram_addr_d;
        end
    end

    assign ram_addr = rst ? '0 : ram_addr_d;
    assign ram_we   = (gnt0 & we0) | (gnt1 & we1);
    assign ram_d    = gnt1 ? wdata1 : wdata0;
    assign rdata    = ram_q;

    bidir_arb_rsp u_rsp (
        .clk     (clk),
        .rst     (rst),
        .rd_vld  ((gnt0 & ~we0) | (gnt1 & ~we1)),
        .rd_id   (gnt1 ? OWNER1 : OWNER0),
        .rvalid0 (rvalid0),
        .rvalid1 (rvalid1)
    );
endmodule

// File: tb/tb_bidir_ram_arbiter.sv
// tb_bidir_ram_arbiter: directed scenarios plus random traffic against a behavioural arbiter/RAM model.
module tb_bidir_ram_arbiter;
    localparam int MAXB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [3:0] addr0 = '0, addr1 = '0;
    logic [7:0] wdata0 = '0, wdata1 = '0;
    logic       gnt0, gnt1, rvalid0, rvalid1, ram_we;
    logic [7:0] rdata, ram_d, ram_q;
    logic [3:0] ram_addr;
    logic [7:0] mem [16];

    int checks = 0;
    int errors = 0;

    int         m_owner = -1, m_run = 0, m_last = 1, m_rid = 0, last_grant = -1;
    logic       m_rv = 1'b0;
    logic [3:0] m_addr = '0;
    logic [7:0] m_rdata = '0;
    logic [7:0] m_mem [16];
    logic [5:0] seq;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_d;
        ram_q <= mem[ram_addr];
    end

    bidir_ram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .MAX_BURST(MAXB)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
        .ram_addr(ram_addr), .ram_d(ram_d), .ram_we(ram_we), .ram_q(ram_q)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int model_grant();
        if (!req0 && !req1) return -1;
        if (req0 != req1) return req0 ? 0 : 1;
`ifdef BIDIR_ARB_FIXED_PRIO_EN
        return 0;
`else
        if (m_owner < 0) return 1 - m_last;
        return (m_run < MAXB) ? m_owner : 1 - m_owner;
`endif
    endfunction

    task automatic step();
        int         eg;
        logic       nrv;
        int         nid;
        logic [7:0] nd;
        logic       w;
        nrv = 1'b0;
        nid = 0;
        nd  = '0;
        @(negedge clk);
        eg = rst ? -1 : model_grant();
        check("gnt0", gnt0, eg == 0);
        check("gnt1", gnt1, eg == 1);
        check("rvalid0", rvalid0, !rst && m_rv && m_rid == 0);
        check("rvalid1", rvalid1, !rst && m_rv && m_rid == 1);
        if (!rst && m_rv) check("rdata", rdata, m_rdata);
        if (eg >= 0) m_addr = (eg == 1) ? addr1 : addr0;
        if (rst) m_addr = '0;
        w = (eg == 0) ? we0 : (eg == 1) ? we1 : 1'b0;
        check("ram_addr", ram_addr, m_addr);
        check("ram_we", ram_we, w);
        if (eg >= 0) begin
            if (w) begin
                m_mem[m_addr] = (eg == 1) ? wdata1 : wdata0;
                check("ram_d", ram_d, m_mem[m_addr]);
            end else begin
                nrv = 1'b1;
                nid = eg;
                nd  = m_mem[m_addr];
            end
            m_run   = (eg == m_owner) ? ((m_run < MAXB) ? m_run + 1 : MAXB) : 1;
            m_owner = eg;
            m_last  = eg;
        end else begin
            m_owner = -1;
            m_run   = 0;
        end
        if (rst) begin
            m_last = 1;
            nrv    = 1'b0;
        end
        m_rv       = nrv;
        m_rid      = nid;
        m_rdata    = nd;
        last_grant = eg;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i]   = '0;
            m_mem[i] = '0;
        end
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;

        // write 0xA5 to 3, read it back next cycle
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'd3; wdata0 = 8'hA5;
        step();
        we0 = 1'b0;
        step();
        req0 = 1'b0;
        check("a5_readback", rdata, 8'hA5);
        check("a5_rvalid0", rvalid0, 1'b1);
        step();

        // both read from IDLE after reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        req0 = 1'b1; req1 = 1'b1; addr0 = 4'd3; addr1 = 4'd5;
        step();
        check("both_first", last_grant, 0);
        req0 = 1'b0;
        step();
        check("both_second", last_grant, 1);
        req1 = 1'b0;
        step();

        // negative index -1
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'hF; wdata0 = 8'h3C;
        step();
        we0 = 1'b0;
        step();
        req0 = 1'b0;
        check("neg_readback", rdata, 8'h3C);
        step();

        // burst limit (or fixed priority) with both requesting
        rst = 1'b1;
        step();
        rst = 1'b0;
        req0 = 1'b1; req1 = 1'b1; addr0 = 4'd1; addr1 = 4'd2;
        seq = '0;
        for (int i = 0; i < 6; i++) begin
            step();
            seq[i] = (last_grant == 1);
            if (last_grant == 1) req1 = 1'b0;
        end
`ifdef BIDIR_ARB_FIXED_PRIO_EN
        check("burst_seq", seq, 6'b000000);
`else
        check("burst_seq", seq, 6'b010000);
`endif
        req0 = 1'b0; req1 = 1'b0;
        step();

        // reset right after a read grant
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd3;
        step();
        req0 = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        check("rst_drop_rv0", rvalid0, 1'b0);

        for (int n = 0; n < 500; n++) begin
            if (!req0 && $urandom_range(0, 2) != 0) begin
                req0 = 1'b1; we0 = $urandom_range(0, 1) == 1;
                addr0 = 4'($urandom); wdata0 = 8'($urandom);
            end
            if (!req1 && $urandom_range(0, 2) != 0) begin
                req1 = 1'b1; we1 = $urandom_range(0, 1) == 1;
                addr1 = 4'($urandom); wdata1 = 8'($urandom);
            end
            rst = ($urandom_range(0, 59) == 0);
            step();
            if (last_grant == 0) req0 = 1'b0;
            if (last_grant == 1) req1 = 1'b0;
        end
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
